vc_demux3_buf: RTL
==================

VC_DEMUX3_BUF -- requirements
Module: vc_Demux3Buf

Interface
REQ-001 SHALL have parameter p_nbits, default 1, giving the message payload width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (asserted when 0).
REQ-004 SHALL have port in_val, input, 1 bit: input message valid; label {L}.
REQ-005 SHALL have port in_rdy, output, 1 bit: input accept; label {L}.
REQ-006 SHALL have port in_msg, input, p_nbits: payload; label {Domain in_domain}.
REQ-007 SHALL have port in_domain, input, 1 bit: payload security domain; label {L}.
REQ-008 SHALL have port sel, input, 2 bits: target output, qualified by in_val; label {L}.
REQ-009 SHALL have, for k = 0, 1, 2, port outk_val, output, 1 bit: slot k valid; label {L}.
REQ-010 SHALL have, for k = 0, 1, 2, port outk_rdy, input, 1 bit: consumer k accept; label {L}.
REQ-011 SHALL have, for k = 0, 1, 2, port outk_msg, output, p_nbits: slot k payload; label {Domain outk_domain}.
REQ-012 SHALL have, for k = 0, 1, 2, port outk_domain, output, 1 bit: slot k domain tag; label {L}.
REQ-013 SHALL have port drop_count, output, 4 bits: count of illegal-select messages; label {L}.

Function
REQ-014 SHALL hold one register slot per output: valid bit, p_nbits payload and domain bit.
REQ-015 SHALL define input fire as in_val && in_rdy, and output k fire as outk_val && outk_rdy.
REQ-016 SHALL, for sel 0-2, drive in_rdy = !slot_sel.valid || outsel_rdy (pass-through refill), combinationally from state and outsel_rdy only.
REQ-017 SHALL, on input fire with sel 0-2, load in_msg and in_domain into slot sel and set its valid bit; latency is 1 cycle from input to outk_val.
REQ-018 SHALL leave the other two slots unaffected by an input fire.
REQ-019 SHALL, on output k fire without a same-cycle refill of slot k, clear slot k valid, zero outk_msg and set outk_domain to 0, leaving no residue.
REQ-020 SHALL, on a same-cycle output k fire and refill of slot k, load the new message; valid stays 1 and there is no bubble.
REQ-021 SHALL hold outk_msg and outk_domain stable while outk_val=1 and outk_rdy=0.
REQ-022 SHALL drive outk_msg = 0 whenever outk_val = 0.
REQ-023 SHALL, for sel = 3, drive in_rdy = 1, discard the message and increment drop_count, saturating at 15.
REQ-024 SHALL keep slots independent: a stalled output never blocks messages to another output.
REQ-025 SHALL drive in_rdy from sel even when in_val = 0.

Reset
REQ-026 SHALL, while reset = 0 at a clock edge, clear all slot valid bits, payloads, domain bits and drop_count to 0.
REQ-027 SHALL give reset priority over simultaneous input and output fires; a message presented during reset is lost.
REQ-028 SHALL drive in_rdy = 0 while reset = 0.

Structure
REQ-029 SHALL place the sel encodings (OUT0 = 0, OUT1 = 1, OUT2 = 2, DROP = 3) and the drop_count width in a shared vc constants package.
REQ-030 SHALL implement each output slot as an instance of one sub-module, vc_DomainSlot, instantiated three times.
REQ-031 SHALL make the vc_DomainSlot sub-module a labelled one-entry pipeline register with valid, payload, domain and pass-through refill.

Verification
REQ-032 SHALL cover: p_nbits = 8; send 0xA5 to sel = 1 with domain = 1 and out1_rdy = 1 -> next cycle out1_val = 1, out1_msg = 0xA5, out1_domain = 1, and out0 and out2 idle with msg = 0.
REQ-033 SHALL cover: out0_rdy = 0; send 0x11 to sel 0, then 0x22 to sel 0 -> in_rdy = 0 on the second message; 0x11 is held; out2 traffic still flows.
REQ-034 SHALL cover: slot 2 full with out2_rdy = 1 and a new message to sel 2 in the same cycle -> back-to-back delivery, no bubble.
REQ-035 SHALL cover: 17 messages with sel = 3 -> in_rdy = 1 each cycle, no outk_val asserted, drop_count = 15.
REQ-036 SHALL cover: domain-1 message 0xFF consumed on out0 with no refill -> next cycle out0_msg = 0 and out0_domain = 0.
REQ-037 SHALL cover: reset asserted with all slots full -> next cycle all outk_val = 0, drop_count = 0 and in_rdy = 0 until reset deasserts.

Source files
------------

// File: rtl/vc_demux3_buf_pkg.sv
// Shared constants for the 3-way domain-tagged demux buffer.
package vc_demux3_buf_pkg;

  // Output select encodings; DROP discards the message.
  typedef enum logic [1:0] {
    SelOut0 = 2'd0,
    SelOut1 = 2'd1,
    SelOut2 = 2'd2,
    SelDrop = 2'd3
  } sel_e;

  localparam int unsigned NumOut = 3;
  localparam int unsigned DropW  = 4;
  localparam logic [DropW-1:0] DropMax = {DropW{1'b1}};

endpackage

// File: rtl/vc_demux3_buf_slot.sv
// One-entry pipeline register holding a payload and its security domain tag,
// with pass-through refill. Payload and domain are scrubbed to zero whenever
// the entry drains so no data lingers in an empty slot.
module vc_DomainSlot #(
  parameter int unsigned p_nbits = 1
) (
  input  logic               clk,
  input  logic               reset,      // synchronous, active-low
  input  logic               load_i,     // producer fire targeting this slot
  input  logic [p_nbits-1:0] msg_i,
  input  logic               domain_i,
  output logic               rdy_o,      // slot can accept this cycle
  output logic               val_o,
  input  logic               deq_rdy_i,
  output logic [p_nbits-1:0] msg_o,
  output logic               domain_o
);

  logic               val_q, val_d;
  logic [p_nbits-1:0] msg_q, msg_d;
  logic               dom_q, dom_d;

  assign rdy_o    = !val_q || deq_rdy_i;
  assign val_o    = val_q;
  assign msg_o    = msg_q;
  assign domain_o = dom_q;

  // Next state: refill wins over drain; a drain without refill scrubs the slot.
  always_comb begin
    val_d = val_q;
    msg_d = msg_q;
    dom_d = dom_q;
    if (load_i) begin
      val_d = 1'b1;
      msg_d = msg_i;
      dom_d = domain_i;
    end else if (val_q && deq_rdy_i) begin
      val_d = 1'b0;
      msg_d = '0;
      dom_d = 1'b0;
    end
  end

  // Slot register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q <= 1'b0;
      msg_q <= '0;
      dom_q <= 1'b0;
    end else begin
      val_q <= val_d;
      msg_q <= msg_d;
      dom_q <= dom_d;
    end
  end

endmodule

// File: rtl/vc_demux3_buf.sv
// Three-way demultiplexer with one buffered, domain-tagged slot per output.
// sel = DROP discards the message and bumps a saturating drop counter.
module vc_demux3_buf
  import vc_demux3_buf_pkg::*;
#(
  parameter int unsigned p_nbits = 1
) (
  input  logic               clk,
  input  logic               reset,        // synchronous, active-low
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_msg,
  input  logic               in_domain,
  input  logic [1:0]         sel,
  output logic               out0_val,
  input  logic               out0_rdy,
  output logic [p_nbits-1:0] out0_msg,
  output logic               out0_domain,
  output logic               out1_val,
  input  logic               out1_rdy,
  output logic [p_nbits-1:0] out1_msg,
  output logic               out1_domain,
  output logic               out2_val,
  input  logic               out2_rdy,
  output logic [p_nbits-1:0] out2_msg,
  output logic               out2_domain,
  output logic [DropW-1:0]   drop_count
);

  logic [NumOut-1:0]  slot_rdy;
  logic [NumOut-1:0]  slot_val;
  logic [NumOut-1:0]  deq_rdy;
  logic [NumOut-1:0]  load;
  logic [NumOut-1:0]  slot_dom;
  logic [p_nbits-1:0] slot_msg [NumOut];
  logic [DropW-1:0]   drop_q, drop_d;
  logic               in_fire;
  sel_e               sel_w;

  assign sel_w   = sel_e'(sel);
  assign deq_rdy = {out2_rdy, out1_rdy, out0_rdy};
  assign in_fire = in_val && in_rdy;

  // Input ready depends only on reset, sel and the selected slot, never on in_val.
  always_comb begin
    in_rdy = 1'b0;
    if (reset) begin
      case (sel_w)
        SelOut0: in_rdy = slot_rdy[0];
        SelOut1: in_rdy = slot_rdy[1];
        SelOut2: in_rdy = slot_rdy[2];
        default: in_rdy = 1'b1;
      endcase
    end
  end

  // Route an accepted message to exactly one slot.
  always_comb begin
    load = '0;
    if (in_fire && (sel_w != SelDrop)) begin
      load[sel] = 1'b1;
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_slot
    vc_DomainSlot #(
      .p_nbits (p_nbits)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load[k]),
      .msg_i     (in_msg),
      .domain_i  (in_domain),
      .rdy_o     (slot_rdy[k]),
      .val_o     (slot_val[k]),
      .deq_rdy_i (deq_rdy[k]),
      .msg_o     (slot_msg[k]),
      .domain_o  (slot_dom[k])
    );
  end

  assign out0_val    = slot_val[0];
  assign out1_val    = slot_val[1];
  assign out2_val    = slot_val[2];
  assign out0_msg    = slot_msg[0];
  assign out1_msg    = slot_msg[1];
  assign out2_msg    = slot_msg[2];
  assign out0_domain = slot_dom[0];
  assign out1_domain = slot_dom[1];
  assign out2_domain = slot_dom[2];

  // Saturating count of discarded messages.
  always_comb begin
    drop_d = drop_q;
    if (in_fire && (sel_w == SelDrop) && (drop_q != DropMax)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

endmodule
